// File: rtl/nrammux_pkg.sv
// Shared types, limits and helpers for the nrammux_pipe scratch RAM.
package nrammux_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int RD_LAT_MAX = 2;

  // Unsigned address-in-range test against the configured word count.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/nrammux_rd_pipe.sv
// Read-data/valid delay line: LAT registered stages, each stage loads data only
// when its incoming valid is set, so the last stage holds its value between reads.
module nrammux_rd_pipe
  import nrammux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int LAT_C = (LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((LAT < 1) ? 1 : LAT);

  logic [DATA_W-1:0] data_q [LAT_C];
  logic [LAT_C-1:0]  valid_q;

  // Shift stages; reset drops anything in flight and clears the held output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT_C; k++) begin
        data_q[k] <= {DATA_W{1'b0}};
      end
      valid_q <= {LAT_C{1'b0}};
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int k = 1; k < LAT_C; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign valid_o = valid_q[LAT_C-1];
  assign data_o  = data_q[LAT_C-1];

endmodule

// File: rtl/nrammux_pipe.sv
// DEPTH x DATA_W one-write/one-read scratch RAM with post-reset zeroing sweep,
// pipelined reads and a sticky range-error flag. NRAMMUX_BYPASS_EN forwards io_D.
module nrammux_pipe
  import nrammux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] io_D,
  input  logic [ADDR_W-1:0] io_WADD,
  input  logic              io_WEN,
  input  logic [ADDR_W-1:0] io_RADD,
  input  logic              io_REN,
  output logic [DATA_W-1:0] io_Q,
  output logic              io_QVALID,
  output logic              io_INIT_DONE,
  output logic              io_ERR
);

  localparam int MEM_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            init_done_q, err_q, err_d;

  logic              wr_ok_s, rd_ok_s, run_s;
  logic              mem_we_s, rd_fire_s;
  logic [MEM_W-1:0]  mem_wa_s;
  logic [DATA_W-1:0] mem_wd_s, rd_data_s;

  assign run_s   = (state_q == RUN);
  assign wr_ok_s = in_range(32'(io_WADD), 32'(DEPTH));
  assign rd_ok_s = in_range(32'(io_RADD), 32'(DEPTH));

  // Sweep sequencing, write-port steering and error accumulation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    mem_we_s = 1'b0;
    mem_wa_s = io_WADD[MEM_W-1:0];
    mem_wd_s = io_D;
    case (state_q)
      INIT: begin
        mem_we_s = 1'b1;
        mem_wa_s = cnt_q[MEM_W-1:0];
        mem_wd_s = {DATA_W{1'b0}};
        cnt_d    = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        if (cnt_q == LAST_C) begin
          state_d = RUN;
        end else begin
          state_d = INIT;
        end
      end
      RUN: begin
        mem_we_s = io_WEN & wr_ok_s;
        if ((io_WEN & ~wr_ok_s) | (io_REN & ~rd_ok_s)) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = {(ADDR_W+1){1'b0}};
      end
    endcase
  end

  // Array read: out-of-range returns zero; optional same-address forwarding.
  always_comb begin
    rd_fire_s = io_REN & run_s;
    if (rd_ok_s) begin
      rd_data_s = mem[io_RADD[MEM_W-1:0]];
`ifdef NRAMMUX_BYPASS_EN
      if (io_WEN && (io_WADD == io_RADD)) begin
        rd_data_s = io_D;
      end else begin
        rd_data_s = mem[io_RADD[MEM_W-1:0]];
      end
`endif
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end
  end

  // Control state; contents of the array are cleared by the sweep, not here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      cnt_q       <= {(ADDR_W+1){1'b0}};
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == RUN);
      err_q       <= err_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_wa_s] <= mem_wd_s;
    end
  end

  nrammux_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (reset),
    .valid_i (rd_fire_s),
    .data_i  (rd_data_s),
    .valid_o (io_QVALID),
    .data_o  (io_Q)
  );

  assign io_INIT_DONE = init_done_q;
  assign io_ERR       = err_q;

endmodule

// File: tb/tb_nrammux_pipe.sv
// Random-traffic bench driving two configurations (64 words/1-cycle, 48 words/2-cycle)
// against an edge-indexed reference model of the RAM.
module tb_nrammux_pipe;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int NE = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] d;
  logic [AW-1:0] wadd, radd;
  logic          wen, ren;
  logic [DW-1:0] q_a, q_b;
  logic          qv_a, qv_b, done_a, done_b, err_a, err_b;

  always #5 clk = ~clk;

  nrammux_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset), .io_D(d), .io_WADD(wadd), .io_WEN(wen),
    .io_RADD(radd), .io_REN(ren), .io_Q(q_a), .io_QVALID(qv_a),
    .io_INIT_DONE(done_a), .io_ERR(err_a)
  );

  nrammux_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(48), .RD_LAT(2)) u_dut_b (
    .clk(clk), .reset(reset), .io_D(d), .io_WADD(wadd), .io_WEN(wen),
    .io_RADD(radd), .io_REN(ren), .io_Q(q_b), .io_QVALID(qv_b),
    .io_INIT_DONE(done_b), .io_ERR(err_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int e;
  int dep [2] = '{64, 48};
  int lat [2] = '{1, 2};
  int mem_m  [2][64];
  int err_m  [2];
  int last_q [2];
  int exp_v  [2][NE];
  int exp_d  [2][NE];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, e, obs, expv);
    end
  endtask

  task automatic model_reset();
    e = 0;
    for (int k = 0; k < 2; k++) begin
      err_m[k]  = 0;
      last_q[k] = 0;
      for (int a = 0; a < 64; a++) mem_m[k][a] = 0;
      for (int i = 0; i < NE; i++) begin
        exp_v[k][i] = 0;
        exp_d[k][i] = 0;
      end
    end
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    int wa, ra, rd;
    e++;
    wa = int'(wadd);
    ra = int'(radd);
    for (int k = 0; k < 2; k++) begin
      if (e > dep[k]) begin
        if (ren) begin
          rd = (ra < dep[k]) ? mem_m[k][ra] : 0;
`ifdef NRAMMUX_BYPASS_EN
          if (wen && wa == ra && ra < dep[k]) rd = int'(d);
`endif
          if (e + lat[k] - 1 < NE) begin
            exp_v[k][e + lat[k] - 1] = 1;
            exp_d[k][e + lat[k] - 1] = rd;
          end
          if (ra >= dep[k]) err_m[k] = 1;
        end
        if (wen) begin
          if (wa < dep[k]) mem_m[k][wa] = int'(d);
          else err_m[k] = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0] oq;
    logic          ov, od, oe;
    string         sfx;
    for (int k = 0; k < 2; k++) begin
      oq  = (k == 0) ? q_a    : q_b;
      ov  = (k == 0) ? qv_a   : qv_b;
      od  = (k == 0) ? done_a : done_b;
      oe  = (k == 0) ? err_a  : err_b;
      sfx = (k == 0) ? "_a" : "_b";
      chk({"qvalid", sfx}, 32'(ov), 32'(exp_v[k][e]));
      if (exp_v[k][e] != 0) last_q[k] = exp_d[k][e];
      chk({"q", sfx}, 32'(oq), 32'(last_q[k]));
      chk({"init_done", sfx}, 32'(od), (e >= dep[k]) ? 32'd1 : 32'd0);
      chk({"err", sfx}, 32'(oe), 32'(err_m[k]));
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 15) == 0) return AW'($urandom_range(0, 63));
    else return AW'($urandom_range(0, 15));
  endfunction

  task automatic drive_random();
    d    = DW'($urandom);
    wen  = 1'($urandom_range(0, 1));
    ren  = 1'($urandom_range(0, 1));
    wadd = rnd_addr();
    radd = ($urandom_range(0, 3) == 0) ? wadd : rnd_addr();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_random();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
    end
  endtask

  // Asynchronous assert between edges; outputs must clear before the next edge.
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    d = '0; wadd = '0; radd = '0; wen = 1'b0; ren = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    run_cycles(450);

    // Read accepted just before reset must never surface.
    d = DW'($urandom); wen = 1'b0; ren = 1'b1; radd = 6'd3; wadd = 6'd0;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    do_reset();

    run_cycles(20);
    do_reset();
    run_cycles(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
